actor_motion_ctrl: RTL and testbench

//  Parametrised successor to the player motion block: moves one sprite actor (player or enemy) through the pillar-grid arena.

---
 rtl/actor_motion_ctrl.sv | 163 ++++++++++++++++
 tb/tb_actor_motion_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/actor_motion_ctrl.sv
// Moves one sprite actor through the pillar-grid arena and produces its sprite ROM address.
// Define CORNER_SLIDE_EN to let an actor slide around a single pillar corner.
module actor_motion_ctrl #(
   parameter int unsigned TILE_LOG2   = 4,
   parameter int unsigned ARENA_X0    = 48,
   parameter int unsigned ARENA_Y0    = 32,
   parameter int unsigned ARENA_X1    = 576,
   parameter int unsigned ARENA_Y1    = 448,
   parameter int unsigned SPR_W       = 16,
   parameter int unsigned SPR_H       = 25,
   parameter int unsigned HB_OFF      = 9,
   parameter int unsigned STEP_TICKS  = 1200000,
   parameter int unsigned FRAME_TICKS = 12500000,
   parameter int unsigned INIT_X      = 64,
   parameter int unsigned INIT_Y      = 23
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        dir_valid,
   input  logic [1:0]  dir,
   input  logic        blocked,
   input  logic        freeze,
   input  logic [1:0]  speed,
   output logic [9:0]  x_a,
   output logic [9:0]  y_a,
   output logic        actor_on,
   output logic        hb_on,
   output logic [11:0] rom_addr,
   output logic        step_pulse
);
   localparam int unsigned STEP_W = $clog2(STEP_TICKS + 1);
   localparam int unsigned FRM_W  = $clog2(FRAME_TICKS + 1);
   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_RIGHT = 2'b01;
   localparam logic [1:0] DIR_DOWN  = 2'b10;
   localparam logic [1:0] DIR_LEFT  = 2'b11;

   logic [STEP_W-1:0] step_cnt, period;
   logic [FRM_W-1:0]  frm_cnt;
   logic [1:0]        phase;
   logic [3:0]        frame, frame_nxt, walk, base;
   logic              mirror;
   logic              tick, frm_tick;
   logic [9:0]        cand_x, cand_y, mv_x, mv_y;
   logic [9:0]        a_x, a_y, b_x, b_y;
   logic              a_hit, b_hit, mv_ok;
   logic [9:0]        dx, dy, col;

   // Pillars sit where both arena-relative coordinates have the tile bit set.
   function automatic logic is_pillar(input logic [9:0] px, input logic [9:0] py);
      logic [9:0] rx, ry;
      rx = px - 10'(ARENA_X0);
      ry = py - 10'(ARENA_Y0);
      return |(((rx & ry) >> TILE_LOG2) & 10'd1);
   endfunction

   function automatic logic in_arena(input logic [9:0] px, input logic [9:0] py);
      return (px >= 10'(ARENA_X0)) && (px <= 10'(ARENA_X1 - SPR_W)) &&
             (py >= 10'(ARENA_Y0 - HB_OFF)) && (py <= 10'(ARENA_Y1 - SPR_H));
   endfunction

   always_comb begin
      period = STEP_W'(STEP_TICKS >> speed);
      if (period == '0) period = STEP_W'(1);
   end

   assign tick     = dir_valid && (step_cnt >= period - STEP_W'(1));
   assign frm_tick = dir_valid && (frm_cnt >= FRM_W'(FRAME_TICKS - 1));

   always_comb begin
      cand_x = x_a;
      cand_y = y_a;
      case (dir)
         DIR_UP:    cand_y = y_a - 10'd1;
         DIR_RIGHT: cand_x = x_a + 10'd1;
         DIR_DOWN:  cand_y = y_a + 10'd1;
         default:   cand_x = x_a - 10'd1;
      endcase
   end

   // Leading-edge corners of the candidate hitbox: a is the left/top one, b the right/bottom one.
   assign a_x   = (dir == DIR_RIGHT) ? cand_x + 10'(SPR_W - 1) : cand_x;
   assign a_y   = (dir == DIR_DOWN)  ? cand_y + 10'(SPR_H - 1) : cand_y + 10'(HB_OFF);
   assign b_x   = (dir == DIR_LEFT)  ? cand_x : cand_x + 10'(SPR_W - 1);
   assign b_y   = (dir == DIR_UP)    ? cand_y + 10'(HB_OFF) : cand_y + 10'(SPR_H - 1);
   assign a_hit = is_pillar(a_x, a_y);
   assign b_hit = is_pillar(b_x, b_y);

   always_comb begin
      mv_ok = 1'b0;
      mv_x  = cand_x;
      mv_y  = cand_y;
      if (in_arena(cand_x, cand_y) && !a_hit && !b_hit) begin
         mv_ok = 1'b1;
      end
`ifdef CORNER_SLIDE_EN
      // Slide toward the free corner; the pixel just beyond that corner must be clear too.
      else if (in_arena(cand_x, cand_y) && (a_hit != b_hit)) begin
         if (!dir[0]) begin
            mv_y  = y_a;
            mv_x  = a_hit ? x_a + 10'd1 : x_a - 10'd1;
            mv_ok = a_hit ? !is_pillar(b_x + 10'd1, b_y) : !is_pillar(a_x - 10'd1, a_y);
         end else begin
            mv_x  = x_a;
            mv_y  = a_hit ? y_a + 10'd1 : y_a - 10'd1;
            mv_ok = a_hit ? !is_pillar(b_x, b_y + 10'd1) : !is_pillar(a_x, a_y - 10'd1);
         end
         mv_ok = mv_ok && in_arena(mv_x, mv_y);
      end
`endif
   end

   always_comb begin
      walk = 4'd0;
      if (phase == 2'd1) walk = 4'd1;
      else if (phase == 2'd3) walk = 4'd2;
      case (dir)
         DIR_UP:   base = 4'd0;
         DIR_DOWN: base = 4'd6;
         default:  base = 4'd3;
      endcase
      frame_nxt = freeze ? 4'd9 : base + walk;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_a        <= 10'(INIT_X);
         y_a        <= 10'(INIT_Y);
         step_cnt   <= '0;
         frm_cnt    <= '0;
         phase      <= 2'd0;
         frame      <= 4'd0;
         mirror     <= 1'b0;
         step_pulse <= 1'b0;
      end else begin
         step_pulse <= 1'b0;
         if (!dir_valid || tick) step_cnt <= '0;
         else                    step_cnt <= step_cnt + STEP_W'(1);
         if (tick && !freeze && !blocked && mv_ok) begin
            x_a        <= mv_x;
            y_a        <= mv_y;
            step_pulse <= 1'b1;
         end
         if (!dir_valid || frm_tick) frm_cnt <= '0;
         else                        frm_cnt <= frm_cnt + FRM_W'(1);
         if (!dir_valid)    phase <= 2'd0;
         else if (frm_tick) phase <= phase + 2'd1;
         frame  <= frame_nxt;
         mirror <= (dir == DIR_LEFT) && !freeze;
      end
   end

   // Pixel-side lookup; rom_addr is meaningful only while actor_on.
   assign dx       = x - x_a;
   assign dy       = y - y_a;
   assign actor_on = (dx < 10'(SPR_W)) && (dy < 10'(SPR_H));
   assign hb_on    = (dx < 10'(SPR_W)) && (dy >= 10'(HB_OFF)) && (dy < 10'(SPR_H));
   assign col      = mirror ? 10'(SPR_W - 1) - dx : dx;
   assign rom_addr = 12'((12'(dy) + 12'(frame) * 12'(SPR_H)) * 12'(SPR_W)) + 12'(col);

endmodule

// File: tb/tb_actor_motion_ctrl.sv
// Self-checking bench for actor_motion_ctrl: vector table, corner-case sequences and
// randomized stimulus against a cycle-level behavioural model.
module tb_actor_motion_ctrl;
   localparam int STEP = 8, FRAME = 16;
   localparam int X0 = 48, Y0 = 32, X1 = 576, Y1 = 448;
   localparam int SW = 16, SH = 25, HB = 9, TILE = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  x = '0, y = '0;
   logic        dir_valid = 1'b0;
   logic [1:0]  dir = 2'd0;
   logic        blocked = 1'b0;
   logic        freeze = 1'b0;
   logic [1:0]  speed = 2'd0;
   logic [9:0]  x_a, y_a;
   logic        actor_on, hb_on, step_pulse;
   logic [11:0] rom_addr;

   always #5 clk = ~clk;

   actor_motion_ctrl #(.STEP_TICKS(STEP), .FRAME_TICKS(FRAME)) dut (
      .clk(clk), .reset(reset), .x(x), .y(y), .dir_valid(dir_valid), .dir(dir),
      .blocked(blocked), .freeze(freeze), .speed(speed), .x_a(x_a), .y_a(y_a),
      .actor_on(actor_on), .hb_on(hb_on), .rom_addr(rom_addr), .step_pulse(step_pulse)
   );

   int n_checks = 0, n_fail = 0;
   int mx, my, scnt, fcnt, mphase, mframe;
   bit mmirror, mpulse;
   bit rand_xy = 1'b1;
   int dxt[4] = '{0, 1, 0, -1};
   int dyt[4] = '{-1, 0, 1, 0};
   int walk_of[4] = '{0, 1, 0, 2};

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit pil(input int px, input int py);
      int rx, ry;
      rx = (px - X0) & 1023;
      ry = (py - Y0) & 1023;
      return ((rx / TILE) % 2 == 1) && ((ry / TILE) % 2 == 1);
   endfunction

   function automatic bit arena(input int px, input int py);
      return px >= X0 && px <= X1 - SW && py >= Y0 - HB && py <= Y1 - SH;
   endfunction

   task automatic model_reset();
      mx = 64; my = 23; scnt = 0; fcnt = 0; mphase = 0; mframe = 0; mmirror = 0; mpulse = 0;
   endtask

   // One clock edge of behaviour, using the inputs as held across the edge.
   task automatic model_edge();
      int per, cx, cy, ax, ay, bx, by, nx, ny, qx, qy, s, d, base;
      bit tk, ftk, ah, bh, ok;
      d   = int'(dir);
      per = STEP >> speed;
      if (per < 1) per = 1;
      tk  = dir_valid && (scnt >= per - 1);
      ftk = dir_valid && (fcnt >= FRAME - 1);
      mpulse = 0;
      if (tk && !freeze && !blocked) begin
         cx = mx + dxt[d];
         cy = my + dyt[d];
         case (d)
            0: begin ax = cx;          ay = cy + HB;     bx = cx + SW - 1; by = cy + HB;     end
            1: begin ax = cx + SW - 1; ay = cy + HB;     bx = cx + SW - 1; by = cy + SH - 1; end
            2: begin ax = cx;          ay = cy + SH - 1; bx = cx + SW - 1; by = cy + SH - 1; end
            default: begin ax = cx;    ay = cy + HB;     bx = cx;          by = cy + SH - 1; end
         endcase
         ah = pil(ax, ay);
         bh = pil(bx, by);
         ok = 0; nx = cx; ny = cy;
         if (arena(cx, cy) && !ah && !bh) ok = 1;
`ifdef CORNER_SLIDE_EN
         else if (arena(cx, cy) && ah != bh) begin
            s = ah ? 1 : -1;
            if (d % 2 == 0) begin
               nx = mx + s; ny = my;
               qx = ah ? bx + 1 : ax - 1; qy = ah ? by : ay;
            end else begin
               nx = mx; ny = my + s;
               qx = ah ? bx : ax; qy = ah ? by + 1 : ay - 1;
            end
            ok = !pil(qx, qy) && arena(nx, ny);
         end
`endif
         if (ok) begin mx = nx; my = ny; mpulse = 1; end
      end
      scnt = (!dir_valid || tk) ? 0 : scnt + 1;
      fcnt = (!dir_valid || ftk) ? 0 : fcnt + 1;
      base = (d == 0) ? 0 : (d == 2) ? 6 : 3;
      mframe  = freeze ? 9 : base + walk_of[mphase];
      mmirror = (d == 3) && !freeze;
      mphase  = !dir_valid ? 0 : ftk ? (mphase + 1) % 4 : mphase;
   endtask

   task automatic check_all();
      int ddx, ddy, col;
      bit on, hb;
      check("x_a", int'(x_a), mx);
      check("y_a", int'(y_a), my);
      check("step_pulse", int'(step_pulse), int'(mpulse));
      ddx = int'(x) - mx;
      ddy = int'(y) - my;
      on  = ddx >= 0 && ddx < SW && ddy >= 0 && ddy < SH;
      hb  = on && ddy >= HB;
      check("actor_on", int'(actor_on), int'(on));
      check("hb_on", int'(hb_on), int'(hb));
      if (on) begin
         col = mmirror ? SW - 1 - ddx : ddx;
         check("rom_addr", int'(rom_addr), ((ddy + mframe * SH) * SW + col) % 4096);
      end
   endtask

   task automatic tick_cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      if (rand_xy) begin
         x = 10'(mx + int'($urandom_range(0, 21)) - 3);
         y = 10'(my + int'($urandom_range(0, 29)) - 3);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      #1;
      check_all();
      #1 reset = 1'b0;
   endtask

   task automatic drive(input bit dv, input logic [1:0] d, input logic [1:0] spd,
                        input bit blk, input bit frz);
      dir_valid = dv; dir = d; speed = spd; blocked = blk; freeze = frz;
   endtask

   typedef struct {
      bit rst; bit dv; logic [1:0] d; logic [1:0] spd; bit blk; bit frz;
      int ncyc; int ex; int ey; int ep;
   } vec_t;
   vec_t vecs[11];

   initial begin
      int pulses;
      vecs[0]  = '{1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 80, 74, 23, 10};
      vecs[1]  = '{1'b1, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 20, 74, 23, 10};
      vecs[2]  = '{1'b1, 1'b1, 2'd3, 2'd3, 1'b0, 1'b0, 40, 48, 23, 16};
      vecs[3]  = '{1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 40, 48, 23, 0};
      vecs[4]  = '{1'b1, 1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 10, 64, 23, 0};
      vecs[5]  = '{1'b1, 1'b1, 2'd2, 2'd3, 1'b0, 1'b0, 10, 64, 23, 0};
      vecs[6]  = '{1'b0, 1'b1, 2'd1, 2'd3, 1'b0, 1'b0, 10, 74, 23, 10};
`ifdef CORNER_SLIDE_EN
      vecs[7]  = '{1'b0, 1'b1, 2'd2, 2'd3, 1'b0, 1'b0, 10, 80, 27, 10};
`else
      vecs[7]  = '{1'b0, 1'b1, 2'd2, 2'd3, 1'b0, 1'b0, 10, 74, 23, 0};
`endif
      vecs[8]  = '{1'b1, 1'b1, 2'd1, 2'd3, 1'b1, 1'b0, 20, 64, 23, 0};
      vecs[9]  = '{1'b1, 1'b1, 2'd1, 2'd3, 1'b0, 1'b1, 20, 64, 23, 0};
      vecs[10] = '{1'b1, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0, 20, 64, 23, 0};

      model_reset();
      #12 reset = 1'b0;
      check_all();

      foreach (vecs[i]) begin
         if (vecs[i].rst) do_reset();
         drive(vecs[i].dv, vecs[i].d, vecs[i].spd, vecs[i].blk, vecs[i].frz);
         pulses = 0;
         for (int c = 0; c < vecs[i].ncyc; c++) begin
            tick_cycle();
            if (step_pulse) pulses++;
         end
         check($sformatf("vec%0d x_a", i), int'(x_a), vecs[i].ex);
         check($sformatf("vec%0d y_a", i), int'(y_a), vecs[i].ey);
         check($sformatf("vec%0d pulses", i), pulses, vecs[i].ep);
      end

      // Speed raised mid-count: the >= compare ticks on the very next edge.
      do_reset();
      drive(1, 2'd1, 2'd0, 0, 0);
      repeat (5) tick_cycle();
      speed = 2'd3;
      tick_cycle();
      check("speed_change x_a", int'(x_a), 65);
      check("speed_change pulse", int'(step_pulse), 1);

      // Releasing dir_valid clears the step count; changing dir does not.
      do_reset();
      drive(1, 2'd1, 2'd0, 0, 0);
      repeat (7) tick_cycle();
      dir_valid = 1'b0;
      tick_cycle();
      dir_valid = 1'b1;
      repeat (7) tick_cycle();
      check("dv_clear held", int'(x_a), 64);
      tick_cycle();
      check("dv_clear step", int'(x_a), 65);
      do_reset();
      drive(1, 2'd1, 2'd0, 0, 0);
      repeat (4) tick_cycle();
      dir = 2'd3;
      repeat (4) tick_cycle();
      check("dir_change step", int'(x_a), 63);

      // Asynchronous reset mid-motion.
      do_reset();
      drive(1, 2'd1, 2'd3, 0, 0);
      repeat (5) tick_cycle();
      reset = 1'b1;
      model_reset();
      #1;
      check("async_reset x_a", int'(x_a), 64);
      check("async_reset y_a", int'(y_a), 23);
      #1 reset = 1'b0;

      // Walk animation at a fixed pixel (blocked keeps the actor still).
      do_reset();
      rand_xy = 1'b0;
      x = 10'd64; y = 10'd23;
      drive(1, 2'd1, 2'd0, 1, 0);
      for (int k = 1; k <= 72; k++) begin
         tick_cycle();
         if (k == 8)  check("anim k8",  int'(rom_addr), 1200);
         if (k == 24) check("anim k24", int'(rom_addr), 1600);
         if (k == 40) check("anim k40", int'(rom_addr), 1200);
         if (k == 56) check("anim k56", int'(rom_addr), 2000);
         if (k == 72) check("anim k72", int'(rom_addr), 1200);
      end
      dir = 2'd3;
      tick_cycle();
      check("mirror col", int'(rom_addr), 1215);
      drive(1, 2'd1, 2'd0, 0, 1);
      tick_cycle();
      check("freeze frame", int'(rom_addr), 3600);
      repeat (10) tick_cycle();
      check("freeze hold", int'(x_a), 64);

      // Sprite box and hitbox edges.
      x = 10'd80; y = 10'd30; #1;
      check("box right edge", int'(actor_on), 0);
      x = 10'd79; y = 10'd31; #1;
      check("box in", int'(actor_on), 1);
      check("hb above", int'(hb_on), 0);
      y = 10'd32; #1;
      check("hb top", int'(hb_on), 1);
      y = 10'd47; #1;
      check("hb bottom", int'(hb_on), 1);
      y = 10'd48; #1;
      check("box bottom edge", int'(actor_on), 0);
      check("hb below", int'(hb_on), 0);

      // Randomized run against the model.
      rand_xy = 1'b1;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c % 16 == 0)
            drive($urandom_range(0, 5) != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0);
         tick_cycle();
         if (c % 700 == 699) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end
endmodule
